// File: rtl/fft_pkg.sv
// Shared types and elaboration-time helpers for the iterative radix-2 FFT.
// Twiddles are quantised from a quarter-wave table of 64-point angles.
package fft_pkg;

    typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int bitrev(input int value, input int bits);
        int r;
        r = 0;
        for (int i = 0; i < bits; i++)
            if (value[i]) r |= 1 << (bits - 1 - i);
        return r;
    endfunction

    // cos(2*pi*j/64) for j = 0..16
    function automatic real qcos(input int j);
        case (j)
            0:  return 1.0;
            1:  return 0.9951847266721969;
            2:  return 0.9807852804032304;
            3:  return 0.9569403357322088;
            4:  return 0.9238795325112867;
            5:  return 0.8819212643483549;
            6:  return 0.8314696123025452;
            7:  return 0.7730104533627370;
            8:  return 0.7071067811865476;
            9:  return 0.6343932841636455;
            10: return 0.5555702330196022;
            11: return 0.4713967368259976;
            12: return 0.3826834323650898;
            13: return 0.2902846772544623;
            14: return 0.1950903220161283;
            15: return 0.0980171403295606;
            default: return 0.0;
        endcase
    endfunction

    function automatic int tw_quant(input real v, input int tw);
        real scale;
        real mag_r;
        int  lim;
        int  mag;
        scale = 1.0;
        for (int i = 0; i < tw - 1; i++) scale = scale * 2.0;
        lim   = (1 << (tw - 1)) - 1;
        mag_r = (v < 0.0) ? -v : v;
        mag   = $rtoi(mag_r * scale + 0.5);
        if (mag > lim) mag = lim;
        return (v < 0.0) ? -mag : mag;
    endfunction

    function automatic int tw_cos(input int m, input int n, input int tw);
        int j;
        j = m * 64 / n;
        return tw_quant((j <= 16) ? qcos(j) : -qcos(32 - j), tw);
    endfunction

    function automatic int tw_sin(input int m, input int n, input int tw);
        int j;
        j = m * 64 / n;
        return tw_quant((j <= 16) ? qcos(16 - j) : qcos(j - 16), tw);
    endfunction

    function automatic logic signed [63:0] rnd_shr(
        input logic signed [63:0] v,
        input int sh
    );
        return (v + (64'sd1 <<< (sh - 1))) >>> sh;
    endfunction

endpackage

// File: rtl/fft_bfly.sv
// Combinational DIT butterfly with per-stage 1/2 scaling.
// W arrives as exp(-j..); conj flips it for the inverse transform.
module fft_bfly
    import fft_pkg::*;
#(
    parameter int DW = 16,
    parameter int TW = 16
) (
    input  logic [2*DW-1:0] a,
    input  logic [2*DW-1:0] b,
    input  logic [2*TW-1:0] w,
    input  logic            conj,
    output logic [2*DW-1:0] ap,
    output logic [2*DW-1:0] bp
);

    localparam int PW = DW + TW + 1;

    logic signed [DW-1:0] ar, ai, br, bi;
    logic signed [TW-1:0] wr, wi;
    logic signed [PW-1:0] pr_full, pi_full;
    logic signed [DW:0]   pr, pi;

    assign ar = a[2*DW-1:DW];
    assign ai = a[DW-1:0];
    assign br = b[2*DW-1:DW];
    assign bi = b[DW-1:0];
    assign wr = w[2*TW-1:TW];
    assign wi = conj ? -$signed(w[TW-1:0]) : $signed(w[TW-1:0]);

    assign pr_full = PW'(wr) * PW'(br) - PW'(wi) * PW'(bi);
    assign pi_full = PW'(wr) * PW'(bi) + PW'(wi) * PW'(br);

    // one guard bit on P keeps |W*B| up to sqrt(2) from wrapping
    assign pr = (DW+1)'(rnd_shr(64'(pr_full), TW - 1));
    assign pi = (DW+1)'(rnd_shr(64'(pi_full), TW - 1));

    assign ap = {DW'(rnd_shr(64'(ar) + 64'(pr), 1)),
                 DW'(rnd_shr(64'(ai) + 64'(pi), 1))};
    assign bp = {DW'(rnd_shr(64'(ar) - 64'(pr), 1)),
                 DW'(rnd_shr(64'(ai) - 64'(pi), 1))};

endmodule

// File: rtl/fft_r2_iter.sv
// Iterative in-place radix-2 DIT FFT/IFFT: bit-reversed load,
// one butterfly per cycle, natural-order unload with backpressure.
module fft_r2_iter
    import fft_pkg::*;
#(
    parameter int N  = 8,
    parameter int DW = 16,
    parameter int TW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inverse,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*DW-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*DW-1:0] out_data,
    output logic            out_last,
    output logic            busy
);

    localparam int LG = clog2(N);
    localparam int SW = clog2(LG);

    state_t state, state_n;

    logic [LG-1:0]   cnt, idx;
    logic [SW-1:0]   s;
    logic [LG-2:0]   k;
    logic            inv_q;
    logic            accept;
    logic [LG-1:0]   waddr;
    logic [LG-1:0]   kx, half, pos, base, aa, ab;
    logic [LG-2:0]   tidx;
    logic [2*DW-1:0] mem [N];
    logic [2*TW-1:0] rom [N/2];
    logic [2*DW-1:0] a_new, b_new;

    for (genvar g = 0; g < N/2; g++) begin : g_rom
        localparam int WR = tw_cos(g, N, TW);
        localparam int WI = -tw_sin(g, N, TW);
        assign rom[g] = {WR[TW-1:0], WI[TW-1:0]};
    end

    assign in_ready  = (state == LOAD) && !rst;
    assign accept    = in_valid && in_ready;
    assign waddr     = LG'(bitrev(int'(cnt), LG));
    assign out_valid = (state == UNLOAD);
    assign out_data  = out_valid ? mem[idx] : '0;
    assign out_last  = out_valid && (idx == '1);
    assign busy      = (state != LOAD);

    // stage s pairs (base|pos, base|pos|half), twiddle pos*N/(2*half)
    always_comb begin
        kx   = {1'b0, k};
        half = LG'(1) << s;
        pos  = kx & (half - LG'(1));
        base = ((kx >> s) << s) << 1;
        aa   = base | pos;
        ab   = base | pos | half;
        tidx = (LG-1)'(pos << (SW'(LG - 1) - s));
    end

    fft_bfly #(
        .DW(DW),
        .TW(TW)
    ) u_bfly (
        .a   (mem[aa]),
        .b   (mem[ab]),
        .w   (rom[tidx]),
        .conj(inv_q),
        .ap  (a_new),
        .bp  (b_new)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            LOAD:    if (accept && cnt == '1) state_n = COMPUTE;
            COMPUTE: if (s == SW'(LG - 1) && k == '1) state_n = UNLOAD;
            UNLOAD:  if (out_ready && idx == '1) state_n = LOAD;
            default: state_n = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[waddr] <= in_data;
        end else if (state == COMPUTE) begin
            mem[aa] <= a_new;
            mem[ab] <= b_new;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
            cnt   <= '0;
            idx   <= '0;
            s     <= '0;
            k     <= '0;
            inv_q <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                cnt <= cnt + LG'(1);
                if (cnt == '0) inv_q <= inverse;
            end
            if (state == COMPUTE) begin
                k <= k + (LG-1)'(1);
                if (k == '1) s <= (s == SW'(LG - 1)) ? '0 : s + SW'(1);
            end
            if (out_valid && out_ready) idx <= idx + LG'(1);
        end
    end

endmodule

// File: tb/tb_fft_r2_iter.sv
// Directed bench for fft_r2_iter at N=8 with hand-derived spectra.
// Each scenario task drives its frame and checks its own results.
module tb_fft_r2_iter;

    localparam int N  = 8;
    localparam int DW = 16;
    localparam int TW = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inverse = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] tone_ref [8];

    always #5 clk = ~clk;

    fft_r2_iter #(.N(N), .DW(DW), .TW(TW)) dut (
        .clk      (clk),
        .rst      (rst),
        .inverse  (inverse),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy)
    );

    function automatic int re_of(input logic [31:0] w);
        return int'($signed(w[31:16]));
    endfunction

    function automatic int im_of(input logic [31:0] w);
        return int'($signed(w[15:0]));
    endfunction

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic send_frame(input logic [31:0] smp [8], input logic inv,
                              input logic toggle, input logic gaps,
                              output int sent);
        int cyc;
        cyc  = 0;
        sent = 0;
        while (sent < N && cyc < 500) begin
            @(negedge clk);
            cyc++;
            inverse = (sent == 0 || !toggle) ? inv : ~inverse;
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = smp[sent];
                if (in_ready) sent++;
            end
        end
    endtask

    task automatic recv_frame(input logic stall, output logic [31:0] res [8],
                              output logic [7:0] lastm, output int got,
                              output int lat, output int stall_bad,
                              output int rdy_bad, output int stalls);
        int cyc;
        logic hold;
        logic [31:0] held;
        logic held_last;
        cyc = 0; hold = 0; held = '0; held_last = 0;
        got = 0; lat = 0; stall_bad = 0; rdy_bad = 0; stalls = 0;
        lastm = '0;
        for (int i = 0; i < N; i++) res[i] = '0;
        while (got < N && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            in_valid = 1'b0;
            if (busy && in_ready) rdy_bad++;
            if (out_valid) begin
                if (lat == 0) lat = cyc;
                if (hold && (out_data !== held || out_last !== held_last))
                    stall_bad++;
                out_ready = !(stall && $urandom_range(0, 2) == 0);
                if (out_ready) begin
                    res[got]   = out_data;
                    lastm[got] = out_last;
                    got++;
                    hold = 0;
                end else begin
                    hold      = 1;
                    held      = out_data;
                    held_last = out_last;
                    stalls++;
                end
            end else begin
                out_ready = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL rst_in_ready got %b want 0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_out_valid got %b want 0", out_valid);
        end
        checks++;
        if (out_data !== 32'h0) begin
            errors++; $display("FAIL rst_out_data got %h want 0", out_data);
        end
        checks++;
        if (out_last !== 1'b0) begin
            errors++; $display("FAIL rst_out_last got %b want 0", out_last);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL rst_busy got %b want 0", busy);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL rel_in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_impulse(input string tag);
        logic [31:0] x [8];
        logic [31:0] r [8];
        logic [7:0]  lm;
        int sent, got, lat, sb, rb, st;
        x = '{default: '0};
        x[0] = 32'h4000_0000;
        send_frame(x, 1'b0, 1'b0, 1'b0, sent);
        recv_frame(1'b0, r, lm, got, lat, sb, rb, st);
        checks++;
        if (got !== N) begin
            errors++; $display("FAIL %s count got %0d want %0d", tag, got, N);
        end
        for (int b = 0; b < N; b++) begin
            checks++;
            if (r[b] !== 32'h0800_0000) begin
                errors++;
                $display("FAIL %s bin%0d got %h want 08000000", tag, b, r[b]);
            end
        end
        checks++;
        if (lm !== 8'h80) begin
            errors++; $display("FAIL %s out_last got %b want 10000000", tag, lm);
        end
    endtask

    task automatic test_dc();
        logic [31:0] x [8];
        logic [31:0] r [8];
        logic [7:0]  lm;
        int sent, got, lat, sb, rb, st;
        x = '{default: 32'h4000_0000};
        send_frame(x, 1'b0, 1'b0, 1'b0, sent);
        recv_frame(1'b0, r, lm, got, lat, sb, rb, st);
        checks++;
        if (lat !== 13) begin
            errors++; $display("FAIL dc_latency got %0d want 13", lat);
        end
        for (int b = 0; b < N; b++) begin
            checks++;
            if (r[b] !== ((b == 0) ? 32'h4000_0000 : 32'h0)) begin
                errors++; $display("FAIL dc bin%0d got %h", b, r[b]);
            end
        end
        checks++;
        if (got !== N) begin
            errors++; $display("FAIL dc count got %0d want %0d", got, N);
        end
    endtask

    task automatic test_tone();
        logic [31:0] x [8];
        logic [7:0]  lm;
        int sent, got, lat, sb, rb, st, er;
        x = '{32'h4000_0000, 32'h2D41_0000, 32'h0, 32'hD2BF_0000,
              32'hC000_0000, 32'hD2BF_0000, 32'h0, 32'h2D41_0000};
        send_frame(x, 1'b0, 1'b0, 1'b0, sent);
        recv_frame(1'b0, tone_ref, lm, got, lat, sb, rb, st);
        for (int b = 0; b < N; b++) begin
            er = (b == 1 || b == 7) ? 8192 : 0;
            checks++;
            if (absd(re_of(tone_ref[b]), er) > 1) begin
                errors++;
                $display("FAIL tone bin%0d re got %0d want %0d+-1",
                         b, re_of(tone_ref[b]), er);
            end
            checks++;
            if (absd(im_of(tone_ref[b]), 0) > 1) begin
                errors++;
                $display("FAIL tone bin%0d im got %0d want 0+-1",
                         b, im_of(tone_ref[b]));
            end
        end
        checks++;
        if (got !== N) begin
            errors++; $display("FAIL tone count got %0d want %0d", got, N);
        end
    endtask

    task automatic test_inverse();
        logic [31:0] x [8];
        logic [31:0] r [8];
        logic [7:0]  lm;
        int sent, got, lat, sb, rb, st;
        int ere [8] = '{2048, 1448, 0, -1448, -2048, -1448, 0, 1448};
        int eim [8] = '{0, 1448, 2048, 1448, 0, -1448, -2048, -1448};
        x = '{default: '0};
        x[1] = 32'h4000_0000;
        send_frame(x, 1'b1, 1'b1, 1'b0, sent);
        recv_frame(1'b0, r, lm, got, lat, sb, rb, st);
        for (int b = 0; b < N; b++) begin
            checks++;
            if (absd(re_of(r[b]), ere[b]) > 2) begin
                errors++;
                $display("FAIL inv x%0d re got %0d want %0d+-2",
                         b, re_of(r[b]), ere[b]);
            end
            checks++;
            if (absd(im_of(r[b]), eim[b]) > 2) begin
                errors++;
                $display("FAIL inv x%0d im got %0d want %0d+-2",
                         b, im_of(r[b]), eim[b]);
            end
        end
        checks++;
        if (got !== N) begin
            errors++; $display("FAIL inv count got %0d want %0d", got, N);
        end
        inverse = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] x [8];
        logic [31:0] r [8];
        logic [7:0]  lm;
        int sent, got, lat, sb, rb, st;
        x = '{32'h4000_0000, 32'h2D41_0000, 32'h0, 32'hD2BF_0000,
              32'hC000_0000, 32'hD2BF_0000, 32'h0, 32'h2D41_0000};
        send_frame(x, 1'b0, 1'b0, 1'b1, sent);
        recv_frame(1'b1, r, lm, got, lat, sb, rb, st);
        for (int b = 0; b < N; b++) begin
            checks++;
            if (r[b] !== tone_ref[b]) begin
                errors++;
                $display("FAIL stress bin%0d got %h want %h", b, r[b], tone_ref[b]);
            end
        end
        checks++;
        if (sb !== 0) begin
            errors++; $display("FAIL stress_stable got %0d changes want 0", sb);
        end
        checks++;
        if (rb !== 0) begin
            errors++; $display("FAIL stress_in_ready got %0d busy cycles want 0", rb);
        end
        checks++;
        if (st == 0) begin
            errors++; $display("FAIL stress_stalls got 0 want >0");
        end
        checks++;
        if (lm !== 8'h80) begin
            errors++; $display("FAIL stress out_last got %b want 10000000", lm);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] x [8];
        int sent, seen;
        x = '{default: '0};
        x[0] = 32'h4000_0000;
        send_frame(x, 1'b0, 1'b0, 1'b0, sent);
        repeat (5) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL mid_busy got %b want 1", busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst outputs got busy=%b rdy=%b vld=%b want 0",
                     busy, in_ready, out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL mid_rel_in_ready got %b want 1", in_ready);
        end
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL mid_stale got %0d out_valid cycles want 0", seen);
        end
        test_impulse("post_rst");
    endtask

    initial begin
        test_reset();
        test_impulse("impulse");
        test_dc();
        test_tone();
        test_inverse();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
